// File: rtl/ring_inject_stage.sv
// ring_inject_stage: one ring stop. It ejects flits addressed to NODE_ID,
// forwards passing flits with one cycle of latency, and injects locally
// queued flits into free or just-vacated ring slots.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-low reset
//   ring_ci    flit arriving from the upstream stop (one slot per cycle)
//   ring_co    registered flit to the downstream stage
//   inj_flit   local flit offered for injection
//   inj_valid  inj_flit is valid this cycle
//   inj_ready  injection FIFO can accept a flit this cycle
//   ej_flit    registered flit ejected at this stop
//   ej_valid   one-cycle pulse per ejected flit
//   inj_stall  saturating count of cycles a queued flit has waited for a slot
//
// Flit layout: [0] valid, [4:1] destination node, [143:5] payload.
module ring_inject_stage #(
  parameter logic [3:0]  NODE_ID = 4'h0,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned STALL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [143:0]       ring_ci,
  output logic [143:0]       ring_co,
  input  logic [143:0]       inj_flit,
  input  logic               inj_valid,
  output logic               inj_ready,
  output logic [143:0]       ej_flit,
  output logic               ej_valid,
  output logic [STALL_W-1:0] inj_stall
);

  localparam int unsigned FLIT_W = 144;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic slot_pass;
  logic slot_eject;
  logic fifo_empty;
  logic push;
  logic pop;

  // Slot decode and FIFO handshake. A passing ring flit always owns the
  // outgoing slot; the FIFO head only goes out when the slot is empty or
  // was just vacated by an ejection.
  always_comb begin
    slot_pass  = ring_ci[0] && (ring_ci[4:1] != NODE_ID);
    slot_eject = ring_ci[0] && (ring_ci[4:1] == NODE_ID);
    fifo_empty = (count == '0);
    inj_ready  = rst && (count < CNT_W'(DEPTH));
    push       = inj_valid && inj_ready;
    pop        = rst && !slot_pass && !fifo_empty;
  end

  // FIFO storage; the valid bit is forced so a queued flit is always live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= inj_flit | FLIT_W'(1);
    end
  end

  // Ring datapath, ejection, FIFO pointers and stall counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ring_co   <= '0;
      ej_flit   <= '0;
      ej_valid  <= 1'b0;
      inj_stall <= '0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      ej_valid <= slot_eject;
      if (slot_eject) begin
        ej_flit <= ring_ci;
      end

      if (slot_pass) begin
        ring_co <= ring_ci;
      end else if (pop) begin
        ring_co <= mem[rd_ptr];
      end else begin
        ring_co <= '0;
      end

      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // Counts only while a queued flit is blocked by passing traffic.
      if (pop || fifo_empty) begin
        inj_stall <= '0;
      end else if (slot_pass && (inj_stall != '1)) begin
        inj_stall <= inj_stall + STALL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ring_inject_stage.sv
// Scoreboard bench for ring_inject_stage (NODE_ID=3, DEPTH=4, STALL_W=8).
// Stimulus pushes expected ring_co / ej_flit values into queues; a monitor
// pops and compares whenever the DUT presents a valid flit.
module tb_ring_inject_stage;

  logic         clk;
  logic         rst;
  logic [143:0] ring_ci;
  logic [143:0] ring_co;
  logic [143:0] inj_flit;
  logic         inj_valid;
  logic         inj_ready;
  logic [143:0] ej_flit;
  logic         ej_valid;
  logic [7:0]   inj_stall;

  int n_tests = 0;
  int n_fail  = 0;

  logic [143:0] exp_ring[$];
  logic [143:0] exp_ej[$];

  ring_inject_stage #(
    .NODE_ID (4'h3),
    .DEPTH   (4),
    .STALL_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ring_ci   (ring_ci),
    .ring_co   (ring_co),
    .inj_flit  (inj_flit),
    .inj_valid (inj_valid),
    .inj_ready (inj_ready),
    .ej_flit   (ej_flit),
    .ej_valid  (ej_valid),
    .inj_stall (inj_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [143:0] mk(input logic [31:0] pay, input logic [3:0] dest,
                                      input logic v);
    mk = {107'h0, pay, dest, v};
  endfunction

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid output flit must match the head of its queue.
  initial begin
    forever begin
      @(negedge clk);
      if (ring_co[0] === 1'b1) begin
        if (exp_ring.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL ring_co unexpected: got %h expected none", ring_co);
        end else begin
          chk("ring_co", ring_co, exp_ring.pop_front());
        end
      end
      if (ej_valid === 1'b1) begin
        if (exp_ej.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL ej_flit unexpected: got %h expected none", ej_flit);
        end else begin
          chk("ej_flit", ej_flit, exp_ej.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [143:0] f1, g, e1, e2;
    logic [143:0] h[5];
    logic [143:0] j[4];

    rst       = 1'b0;
    ring_ci   = '0;
    inj_flit  = '0;
    inj_valid = 1'b0;

    // Reset state
    step();
    step();
    chk("rst ring_co", ring_co, 144'h0);
    chk("rst ej_flit", ej_flit, 144'h0);
    chk("rst ej_valid", 144'(ej_valid), 144'h0);
    chk("rst inj_stall", 144'(inj_stall), 144'h0);
    chk("rst inj_ready", 144'(inj_ready), 144'h0);

    // Single injection into an empty ring, valid bit forced
    rst       = 1'b1;
    inj_flit  = 144'hA0;
    inj_valid = 1'b1;
    #1;
    chk("inj_ready after rst", 144'(inj_ready), 144'h1);
    exp_ring.push_back(144'hA1);
    step();
    inj_valid = 1'b0;
    chk("no bypass ring_co", ring_co, 144'h0);
    step();
    step();
    chk("fifo drained ring_co", ring_co, 144'h0);

    // Eject with FIFO holding F1: F1 fills the vacated slot
    f1        = mk(32'h0000_00F1, 4'd7, 1'b0);
    inj_flit  = f1;
    inj_valid = 1'b1;
    ring_ci   = mk(32'h0000_0200, 4'd2, 1'b1);
    exp_ring.push_back(ring_ci);
    step();
    inj_valid = 1'b0;
    e1        = mk(32'h0000_0055, 4'd3, 1'b1);
    ring_ci   = e1;
    exp_ej.push_back(e1);
    exp_ring.push_back(f1 | 144'h1);
    step();
    chk("eject ej_valid", 144'(ej_valid), 144'h1);
    ring_ci = mk(32'h0000_0077, 4'd3, 1'b0);   // dest matches but invalid: EMPTY
    step();
    chk("empty slot ej_valid", 144'(ej_valid), 144'h0);
    chk("ej_flit holds", ej_flit, e1);
    chk("empty slot ring_co", ring_co, 144'h0);

    // Long PASS stream with one queued flit: stall saturates, FIFO untouched
    g         = mk(32'h0000_BEEF, 4'd5, 1'b0);
    inj_flit  = g;
    inj_valid = 1'b1;
    ring_ci   = mk(32'h0000_3000, 4'd2, 1'b1);
    exp_ring.push_back(ring_ci);
    step();
    inj_valid = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      ring_ci = mk(32'h0000_3000 + 32'(i), 4'd2, 1'b1);
      exp_ring.push_back(ring_ci);
      step();
      if (i == 100) chk("stall 100", 144'(inj_stall), 144'd100);
      if (i == 300) chk("stall saturated", 144'(inj_stall), 144'd255);
    end
    chk("ready with 1 queued", 144'(inj_ready), 144'h1);
    ring_ci = '0;
    exp_ring.push_back(g | 144'h1);
    step();
    chk("stall cleared on pop", 144'(inj_stall), 144'h0);

    // Fill FIFO with ring busy; fifth flit held by source
    for (int k = 0; k < 5; k++) h[k] = mk(32'h0000_4100 + 32'(k), 4'd6, 1'b0);
    for (int k = 0; k < 4; k++) begin
      ring_ci = mk(32'h0000_4000 + 32'(k), 4'd1, 1'b1);
      exp_ring.push_back(ring_ci);
      inj_flit  = h[k];
      inj_valid = 1'b1;
      if (k == 0) chk("ready before first push", 144'(inj_ready), 144'h1);
      step();
    end
    chk("ready full", 144'(inj_ready), 144'h0);
    ring_ci = mk(32'h0000_4004, 4'd1, 1'b1);
    exp_ring.push_back(ring_ci);
    inj_flit = h[4];
    step();
    chk("ready still full", 144'(inj_ready), 144'h0);
    chk("stall while full", 144'(inj_stall), 144'd4);

    // Full FIFO, empty slot, inj_valid held: pop without push
    ring_ci = '0;
    exp_ring.push_back(h[0] | 144'h1);
    step();
    chk("ready after pop from full", 144'(inj_ready), 144'h1);
    chk("stall after pop", 144'(inj_stall), 144'h0);
    exp_ring.push_back(h[1] | 144'h1);
    step();
    inj_valid = 1'b0;
    chk("ready push+pop", 144'(inj_ready), 144'h1);
    exp_ring.push_back(h[2] | 144'h1);
    exp_ring.push_back(h[3] | 144'h1);
    exp_ring.push_back(h[4] | 144'h1);
    step();
    step();
    step();
    step();
    chk("fifo empty again ring_co", ring_co, 144'h0);

    // Reset mid-operation with 3 queued and ej_valid high
    for (int k = 0; k < 4; k++) begin
      j[k]    = mk(32'h0000_6100 + 32'(k), 4'd4, 1'b0);
      ring_ci = mk(32'h0000_6000 + 32'(k), 4'd0, 1'b1);
      exp_ring.push_back(ring_ci);
      inj_flit  = j[k];
      inj_valid = 1'b1;
      step();
    end
    inj_valid = 1'b0;
    e2        = mk(32'h0000_6600, 4'd3, 1'b1);
    ring_ci   = e2;
    exp_ej.push_back(e2);
    exp_ring.push_back(j[0] | 144'h1);
    step();
    chk("pre-reset ej_valid", 144'(ej_valid), 144'h1);
    rst       = 1'b0;
    ring_ci   = mk(32'h0000_6700, 4'd3, 1'b1);
    inj_flit  = mk(32'h0000_6999, 4'd4, 1'b1);
    inj_valid = 1'b1;
    #1;
    chk("inj_ready in reset", 144'(inj_ready), 144'h0);
    step();
    chk("mid-rst ring_co", ring_co, 144'h0);
    chk("mid-rst ej_flit", ej_flit, 144'h0);
    chk("mid-rst ej_valid", 144'(ej_valid), 144'h0);
    chk("mid-rst inj_stall", 144'(inj_stall), 144'h0);
    rst       = 1'b1;
    ring_ci   = '0;
    inj_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post-rst ring_co", ring_co, 144'h0);
    end
    chk("post-rst inj_ready", 144'(inj_ready), 144'h1);

    step();
    step();
    chk("ring queue drained", 144'(exp_ring.size()), 144'h0);
    chk("eject queue drained", 144'(exp_ej.size()), 144'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
